// File: rtl/roxxon_axi_pkg.sv
// Shared AXI4-Lite definitions for the roxxon fetch path: response codes,
// instruction-fetch protection bits and the fetcher state encoding.
package roxxon_axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    // Instruction access, secure, unprivileged
    localparam logic [2:0] ARPROT_INSTR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        DONE = 2'b11
    } fetch_state_t;

    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [31:0] word_idx);
        return base + (word_idx << 2);
    endfunction

endpackage

// File: rtl/instr_axi_fetcher.sv
// Single-beat AXI4-Lite instruction fetcher: turns a one-cycle fetch request
// into an AR/R transaction and presents the returned word with a done pulse.
module instr_axi_fetcher
    import roxxon_axi_pkg::*;
#(
    parameter int          N         = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int         PW        = (N > 1) ? $clog2(N) : 1
)(
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          FETCH_REQ,
    input  logic [PW-1:0] PC_AXI,
    output logic [31:0]   INSTR_AXI,
    output logic          INSTR_DONE,
    output logic          FETCH_BUSY,
    output logic          FETCH_ERR,
    output logic [31:0]   M_ARADDR,
    output logic [2:0]    M_ARPROT,
    output logic          M_ARVALID,
    input  logic          M_ARREADY,
    input  logic [31:0]   M_RDATA,
    input  logic [1:0]    M_RRESP,
    input  logic          M_RVALID,
    output logic          M_RREADY
);

    fetch_state_t state;
    logic         pending;

    assign M_ARPROT   = ARPROT_INSTR;
    assign FETCH_BUSY = (state != IDLE);

    // The byte address is captured together with the PC, so ARADDR is stable
    // for the whole ADDR phase without a separate PC register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state      <= IDLE;
            pending    <= 1'b0;
            INSTR_AXI  <= 32'h0000_0000;
            INSTR_DONE <= 1'b0;
            FETCH_ERR  <= 1'b0;
            M_ARVALID  <= 1'b0;
            M_RREADY   <= 1'b0;
            M_ARADDR   <= BASE_ADDR;
        end else begin
            INSTR_DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (FETCH_REQ) begin
                        M_ARADDR  <= word_byte_addr(BASE_ADDR, 32'(PC_AXI));
                        M_ARVALID <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (FETCH_REQ) begin
                        pending <= 1'b1;
                    end
                    if (M_ARREADY) begin
                        M_ARVALID <= 1'b0;
                        M_RREADY  <= 1'b1;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (FETCH_REQ) begin
                        pending <= 1'b1;
                    end
                    if (M_RVALID) begin
                        // Error responses deliver a NOP so the pipeline never
                        // executes garbage data.
                        if (M_RRESP == OKAY) begin
                            INSTR_AXI <= M_RDATA;
                            FETCH_ERR <= 1'b0;
                        end else begin
                            INSTR_AXI <= 32'h0000_0000;
                            FETCH_ERR <= 1'b1;
                        end
                        INSTR_DONE <= 1'b1;
                        M_RREADY   <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // A queued request (or a fresh one arriving now) is served
                    // back-to-back; a new request while one is queued is dropped.
                    if (pending || FETCH_REQ) begin
                        pending   <= 1'b0;
                        M_ARADDR  <= word_byte_addr(BASE_ADDR, 32'(PC_AXI));
                        M_ARVALID <= 1'b1;
                        state     <= ADDR;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_axi_fetcher.md
INSTR_AXI_FETCHER -- requirements
Module: instr_axi_fetcher

Interface
REQ-001 Parameter N, default 256, instruction memory depth in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of instruction word 0.
REQ-003 CLK  input  1  clock; all logic on rising edge.
REQ-004 RSTN  input  1  reset, synchronous, active-low.
REQ-005 FETCH_REQ  input  1  fetch request from the control unit, one cycle wide.
REQ-006 PC_AXI  input  $clog2(N)  word index to fetch, from the fetch stage.
REQ-007 INSTR_AXI  output  32  last fetched instruction word.
REQ-008 INSTR_DONE  output  1  one-cycle pulse: INSTR_AXI updated and valid.
REQ-009 FETCH_BUSY  output  1  high whenever state is not IDLE.
REQ-010 FETCH_ERR  output  1  last completed fetch returned a non-OKAY response.
REQ-011 M_ARADDR  output  32  AXI4-Lite read address.
REQ-012 M_ARPROT  output  3  constant 3'b100 (instruction, secure, unprivileged).
REQ-013 M_ARVALID  output  1; M_ARREADY  input  1  read-address handshake.
REQ-014 M_RDATA  input  32; M_RRESP  input  2; M_RVALID  input  1; M_RREADY  output  1  read-data channel.

Function
REQ-015 The FSM SHALL have states IDLE, ADDR, DATA and DONE.
REQ-016 IDLE: on FETCH_REQ=1, the block SHALL latch PC_AXI and go to ADDR on the next edge.
REQ-017 M_ARADDR SHALL be BASE_ADDR + {latched PC, 2'b00}, computed modulo 2^32 and registered.
REQ-018 M_ARADDR SHALL remain stable from ADDR entry until the AR handshake completes.
REQ-019 M_ARVALID SHALL be 1 exactly while in ADDR; once asserted, it SHALL NOT drop before M_ARREADY=1.
REQ-020 ADDR: when M_ARVALID&&M_ARREADY, the FSM SHALL go to DATA; ARREADY in the first ADDR cycle SHALL complete the handshake that cycle.
REQ-021 M_RREADY SHALL be 1 exactly while in DATA.
REQ-022 DATA: when M_RVALID&&M_RREADY, the block SHALL register INSTR_AXI<=M_RDATA and FETCH_ERR<=(M_RRESP!=2'b00), then go to DONE.
REQ-023 On a non-OKAY response, INSTR_AXI SHALL instead load 32'h0000_0000 (NOP); FETCH_ERR SHALL be 1.
REQ-024 DONE: INSTR_DONE SHALL be 1 for exactly that one cycle, and the FSM SHALL return to IDLE.
REQ-025 Minimum latency is 4 cycles from FETCH_REQ to INSTR_DONE (zero-wait slave).
REQ-026 INSTR_AXI and FETCH_ERR SHALL hold their value between DONE pulses.
REQ-027 A FETCH_REQ arriving while not in IDLE SHALL set a one-deep pending flag; further requests while pending SHALL be dropped.
REQ-028 In DONE with pending set, the block SHALL clear pending, latch the current PC_AXI and go to ADDR, not IDLE.
REQ-029 M_RVALID arriving outside DATA SHALL be ignored, with M_RREADY held 0.
REQ-030 PC_AXI=N-1 SHALL fetch normally; there is no PC wrap logic in this block.

Reset
REQ-031 With RSTN=0 at a rising edge, the block SHALL enter IDLE, clear pending, set INSTR_AXI=0, INSTR_DONE=0, FETCH_ERR=0, M_ARVALID=0, M_RREADY=0 and M_ARADDR=BASE_ADDR.
REQ-032 A reset mid-transaction SHALL abort immediately; a late M_RVALID after reset SHALL be ignored per REQ-029.

Structure
REQ-033 Shared package roxxon_axi_pkg SHALL hold the AXI resp enum (OKAY, EXOKAY, SLVERR, DECERR), the ARPROT_INSTR constant and the fetcher state typedef.
REQ-034 The block is a single module; no sub-module is required.

Verification
REQ-035 Zero-wait slave, PC_AXI=5, BASE_ADDR=0x1000, RDATA=0xDEADBEEF -> M_ARADDR=0x1014; INSTR_DONE 4 cycles after FETCH_REQ; INSTR_AXI=0xDEADBEEF.
REQ-036 ARREADY delayed 3 cycles, RVALID delayed 2 cycles -> ARVALID and ARADDR stable throughout; single INSTR_DONE pulse; latency 9 cycles.
REQ-037 RRESP=SLVERR, RDATA=0x12345678 -> INSTR_AXI=0, FETCH_ERR=1; next OKAY fetch clears FETCH_ERR.
REQ-038 Second FETCH_REQ while in DATA with PC_AXI changed to 6 -> second AR issued for word 6 directly after DONE; a third request while pending is dropped.
REQ-039 RSTN=0 while in DATA, then RVALID pulse -> outputs at reset values, no INSTR_DONE.
REQ-040 PC_AXI=255 with N=256, BASE_ADDR=0xFFFF_FF00 -> M_ARADDR=0x0000_02FC (modulo wrap).
